// File: rtl/counter4bit_ctrl.sv
// Push-button front end for the 4-bit up/down counter: sync + debounce, run/mode toggles, count-strobe prescaler, validated limit latch.
// Event-to-state latency is 3+DEB_CYCLES edges; SS strobes every DIV cycles while running; no backpressure.

module counter4bit_ctrl_btn #(
    parameter int DEB_CYCLES = 4
) (
    input  logic Clk,
    input  logic RST_N,
    input  logic btn_i,
    input  logic primed_i,
    output logic event_o
);
    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             db_q, db_d;
    logic             db_prev_q;
    logic             armed_q, armed_d;
    logic             sync_lvl;

    assign sync_lvl = sync_q[1];

    always_comb begin
        cnt_d = '0;
        db_d  = db_q;
        if (sync_lvl != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d = ~db_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // A button held through reset must be seen released before it may raise an event.
    assign armed_d = armed_q | (primed_i & ~sync_lvl);

    always_ff @(posedge Clk or negedge RST_N) begin
        if (!RST_N) begin
            sync_q    <= 2'b00;
            cnt_q     <= '0;
            db_q      <= 1'b0;
            db_prev_q <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], btn_i};
            cnt_q     <= cnt_d;
            db_q      <= db_d;
            db_prev_q <= db_q;
            armed_q   <= armed_d;
        end
    end

    assign event_o = db_q & ~db_prev_q & armed_q;
endmodule

module counter4bit_ctrl #(
    parameter int DEB_CYCLES = 4,
    parameter int DIV        = 4
) (
    input  logic       Clk,
    input  logic       RST_N,
    input  logic       BTN_SS,
    input  logic       BTN_MODE,
    input  logic       BTN_LOAD,
    input  logic [3:0] SW_MIN,
    input  logic [3:0] SW_MAX,
    output logic       SS,
    output logic       MODE,
    output logic [3:0] MIN,
    output logic [3:0] MAX,
    output logic       RUN,
    output logic       LIMIT_ERR
);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    typedef enum logic {
        ST_STOP = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state_q;
    logic [DIV_W-1:0] div_q;
    logic             mode_q;
    logic [3:0]       min_q;
    logic [3:0]       max_q;
    logic             err_q;
    logic [1:0]       prime_q;
    logic             ev_ss, ev_mode, ev_load;

    // Synchroniser outputs only reflect the pins after two edges out of reset.
    always_ff @(posedge Clk or negedge RST_N) begin
        if (!RST_N) begin
            prime_q <= 2'b00;
        end else begin
            prime_q <= {prime_q[0], 1'b1};
        end
    end

    counter4bit_ctrl_btn #(.DEB_CYCLES(DEB_CYCLES)) u_btn_ss (
        .Clk      (Clk),
        .RST_N    (RST_N),
        .btn_i    (BTN_SS),
        .primed_i (prime_q[1]),
        .event_o  (ev_ss)
    );

    counter4bit_ctrl_btn #(.DEB_CYCLES(DEB_CYCLES)) u_btn_mode (
        .Clk      (Clk),
        .RST_N    (RST_N),
        .btn_i    (BTN_MODE),
        .primed_i (prime_q[1]),
        .event_o  (ev_mode)
    );

    counter4bit_ctrl_btn #(.DEB_CYCLES(DEB_CYCLES)) u_btn_load (
        .Clk      (Clk),
        .RST_N    (RST_N),
        .btn_i    (BTN_LOAD),
        .primed_i (prime_q[1]),
        .event_o  (ev_load)
    );

    always_ff @(posedge Clk or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_STOP;
            div_q   <= '0;
            mode_q  <= 1'b1;
            min_q   <= 4'h0;
            max_q   <= 4'hF;
            err_q   <= 1'b0;
        end else begin
            // Load decision uses the pre-update state, so LOAD+SS in STOP still loads.
            if (ev_load && (state_q == ST_STOP)) begin
                if (SW_MIN <= SW_MAX) begin
                    min_q <= SW_MIN;
                    max_q <= SW_MAX;
                    err_q <= 1'b0;
                end else begin
                    min_q <= SW_MAX;
                    max_q <= SW_MIN;
                    err_q <= 1'b1;
                end
            end
            if (ev_mode) begin
                mode_q <= ~mode_q;
            end
            case (state_q)
                ST_STOP: begin
                    div_q <= '0;
                    if (ev_ss) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (ev_ss) begin
                        state_q <= ST_STOP;
                        div_q   <= '0;
                    end else if (div_q == DIV_LAST) begin
                        div_q <= '0;
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_STOP;
                    div_q   <= '0;
                end
            endcase
        end
    end

    assign RUN       = (state_q == ST_RUN);
    assign SS        = RUN && (div_q == DIV_LAST);
    assign MODE      = mode_q;
    assign MIN       = min_q;
    assign MAX       = max_q;
    assign LIMIT_ERR = err_q;
endmodule
